ppg_sample_fifo: RTL and testbench

PPG_SAMPLE_FIFO -- requirements
Module: ppg_sample_fifo

---
 rtl/ppg_fifo_pkg.sv | 15 +
 rtl/ppg_ptr_wrap.sv | 43 ++++
 rtl/ppg_sample_fifo.sv | 120 ++++++++++++
 tb/tb_ppg_sample_fifo.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ppg_fifo_pkg.sv
// Shared width helpers and write-when-full mode encodings for the PPG sample FIFO.
package ppg_fifo_pkg;

   localparam int OVW_DROP_NEW = 0;
   localparam int OVW_DROP_OLD = 1;

   function automatic int PTR_W(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int LVL_W(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ppg_ptr_wrap.sv
// Modulo-DEPTH pointer with enable; wraps DEPTH-1 -> 0 for any DEPTH.
module ppg_ptr_wrap
   import ppg_fifo_pkg::*;
#(
   parameter int DEPTH = 24
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   output logic [PTR_W(DEPTH)-1:0] ptr
);

   localparam int W = PTR_W(DEPTH);

   logic [W-1:0] ptr_q;
   logic [W-1:0] ptr_d;

   // Next pointer value
   always_comb begin
      ptr_d = ptr_q;
      if (en) begin
         if (ptr_q == W'(DEPTH - 1)) begin
            ptr_d = {W{1'b0}};
         end else begin
            ptr_d = ptr_q + W'(1);
         end
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Pointer register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q <= {W{1'b0}};
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/ppg_sample_fifo.sv
// Sample FIFO with registered read port, occupancy/status flags and sticky
// overflow/underflow; write-when-full either drops the oldest or the new sample.
module ppg_sample_fifo
   import ppg_fifo_pkg::*;
#(
   parameter int WIDTH     = 10,
   parameter int DEPTH     = 24,
   parameter int OVERWRITE = 1,
   parameter int AFULL_TH  = DEPTH - 4,
   parameter int AEMPTY_TH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [WIDTH-1:0]        wr_data,
   input  logic                    rd_en,
   input  logic                    err_clr,
   output logic [WIDTH-1:0]        rd_data,
   output logic                    rd_valid,
   output logic                    full,
   output logic                    empty,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [LVL_W(DEPTH)-1:0] level,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int  PW     = PTR_W(DEPTH);
   localparam int  LW     = LVL_W(DEPTH);
   localparam bit  OVW_EN = (OVERWRITE == OVW_DROP_OLD);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wptr_s;
   logic [PW-1:0]    rptr_s;
   logic [LW-1:0]    level_q,     level_d;
   logic [WIDTH-1:0] rd_data_q,   rd_data_d;
   logic             rd_valid_q,  rd_valid_d;
   logic             overflow_q,  overflow_d;
   logic             underflow_q, underflow_d;
   logic             full_s, empty_s;
   logic             wr_acc_s, rd_acc_s, wadv_s, radv_s;

   assign full_s  = (level_q == LW'(DEPTH));
   assign empty_s = (level_q == {LW{1'b0}});

   // Accept decisions; an overwrite on full also pushes the read pointer past the dropped entry
   always_comb begin
      rd_acc_s = rd_en & ~empty_s;
      wr_acc_s = wr_en & (~full_s | OVW_EN | rd_acc_s);
      wadv_s   = wr_acc_s;
      radv_s   = rd_acc_s | (wr_acc_s & full_s);
   end

   // Occupancy, read port and sticky error next-state
   always_comb begin
      case ({wr_acc_s, rd_acc_s})
         2'b10:   level_d = full_s ? level_q : level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      rd_valid_d  = rd_acc_s;
      if (rd_acc_s) begin
         rd_data_d = mem_q[rptr_s];
      end else begin
         rd_data_d = rd_data_q;
      end
      overflow_d  = (wr_en & full_s & ~rd_acc_s) | (overflow_q & ~err_clr);
      underflow_d = (rd_en & empty_s) | (underflow_q & ~err_clr);
   end

   // Control and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         level_q     <= {LW{1'b0}};
         rd_data_q   <= {WIDTH{1'b0}};
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         level_q     <= level_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Sample storage, deliberately not reset
   always_ff @(posedge clk) begin
      if (wr_acc_s) begin
         mem_q[wptr_s] <= wr_data;
      end
   end

   ppg_ptr_wrap #(.DEPTH(DEPTH)) u_wptr (
      .clk   (clk),
      .reset (reset),
      .en    (wadv_s),
      .ptr   (wptr_s)
   );

   ppg_ptr_wrap #(.DEPTH(DEPTH)) u_rptr (
      .clk   (clk),
      .reset (reset),
      .en    (radv_s),
      .ptr   (rptr_s)
   );

   assign rd_data      = rd_data_q;
   assign rd_valid     = rd_valid_q;
   assign full         = full_s;
   assign empty        = empty_s;
   assign almost_full  = (level_q >= LW'(AFULL_TH));
   assign almost_empty = (level_q <= LW'(AEMPTY_TH));
   assign level        = level_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_ppg_sample_fifo.sv
// Bench: one drop-new and one drop-oldest FIFO share stimulus; a queue model per mode supplies expectations.
module tb_ppg_sample_fifo;

   localparam int W  = 10;
   localparam int D  = 24;
   localparam int LW = 5;

   logic          clk, reset, wr_en, rd_en, err_clr;
   logic [W-1:0]  wr_data;
   logic [W-1:0]  rd_data [2];
   logic [LW-1:0] level   [2];
   logic          rd_valid[2], full[2], empty[2], afull[2], aempty[2], ovf[2], udf[2];

   int            checks = 0;
   int            errors = 0;

   // Reference model: index 0 drops new samples on full, index 1 drops the oldest
   int            mq     [2][$];
   logic [W-1:0]  m_data [2];
   logic          m_valid[2], m_ovf[2], m_udf[2];

   ppg_sample_fifo #(.WIDTH(W), .DEPTH(D), .OVERWRITE(0)) u_drop_new (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .err_clr(err_clr), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .full(full[0]),
      .empty(empty[0]), .almost_full(afull[0]), .almost_empty(aempty[0]),
      .level(level[0]), .overflow(ovf[0]), .underflow(udf[0])
   );

   ppg_sample_fifo #(.WIDTH(W), .DEPTH(D), .OVERWRITE(1)) u_drop_old (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .err_clr(err_clr), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .full(full[1]),
      .empty(empty[1]), .almost_full(afull[1]), .almost_empty(aempty[1]),
      .level(level[1]), .overflow(ovf[1]), .underflow(udf[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1);
   end

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         mq[m].delete();
         m_data[m]  = '0;
         m_valid[m] = 1'b0;
         m_ovf[m]   = 1'b0;
         m_udf[m]   = 1'b0;
      end
   endtask

   task automatic model_step();
      for (int m = 0; m < 2; m++) begin
         int n     = mq[m].size();
         bit rd_ok = rd_en && (n > 0);
         bit ov_ev = wr_en && (n == D) && !rd_ok;
         m_valid[m] = rd_ok;
         if (rd_ok) m_data[m] = W'(mq[m].pop_front());
         if (wr_en) begin
            if (n < D || rd_ok) begin
               mq[m].push_back(int'(wr_data));
            end else if (m == 1) begin
               void'(mq[m].pop_front());
               mq[m].push_back(int'(wr_data));
            end
         end
         m_ovf[m] = ov_ev || (m_ovf[m] && !err_clr);
         m_udf[m] = (rd_en && n == 0) || (m_udf[m] && !err_clr);
      end
   endtask

   task automatic step(input logic w, input logic r, input logic [W-1:0] d, input logic c);
      wr_en = w; rd_en = r; wr_data = d; err_clr = c;
      @(posedge clk);
      if (reset) model_step();
      #1;
   endtask

   task automatic do_reset();
      #2 reset = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; wr_en = 1'b1; rd_en = 1'b1; err_clr = 1'b0; wr_data = W'($urandom);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         checks++; if (level[m] !== 5'd0)     begin errors++; $display("FAIL rst_level inst%0d got %0d want 0", m, level[m]); end
         checks++; if (empty[m] !== 1'b1)     begin errors++; $display("FAIL rst_empty inst%0d got %b want 1", m, empty[m]); end
         checks++; if (full[m] !== 1'b0)      begin errors++; $display("FAIL rst_full inst%0d got %b want 0", m, full[m]); end
         checks++; if (aempty[m] !== 1'b1)    begin errors++; $display("FAIL rst_aempty inst%0d got %b want 1", m, aempty[m]); end
         checks++; if (afull[m] !== 1'b0)     begin errors++; $display("FAIL rst_afull inst%0d got %b want 0", m, afull[m]); end
         checks++; if (rd_valid[m] !== 1'b0)  begin errors++; $display("FAIL rst_valid inst%0d got %b want 0", m, rd_valid[m]); end
         checks++; if (rd_data[m] !== 10'd0)  begin errors++; $display("FAIL rst_data inst%0d got %0h want 0", m, rd_data[m]); end
         checks++; if ({ovf[m], udf[m]} !== 2'b00) begin errors++; $display("FAIL rst_errs inst%0d got %b want 00", m, {ovf[m], udf[m]}); end
      end
      reset = 1'b1;
      step(1'b1, 1'b0, 10'd7, 1'b0);
      for (int m = 0; m < 2; m++) begin
         checks++; if (level[m] !== 5'd1) begin errors++; $display("FAIL first_write inst%0d got %0d want 1", m, level[m]); end
      end
   endtask

   task automatic test_fill_drain();
      do_reset();
      for (int i = 0; i < D; i++) begin
         step(1'b1, 1'b0, W'(i), 1'b0);
         for (int m = 0; m < 2; m++) begin
            checks++; if (full[m] !== (i == D - 1)) begin errors++; $display("FAIL fill_full inst%0d i=%0d got %b want %b", m, i, full[m], i == D - 1); end
         end
      end
      for (int i = 0; i < D; i++) begin
         step(1'b0, 1'b1, '0, 1'b0);
         for (int m = 0; m < 2; m++) begin
            checks++; if ({rd_valid[m], rd_data[m]} !== {1'b1, W'(i)}) begin errors++; $display("FAIL drain_data inst%0d got v=%b d=%0d want v=1 d=%0d", m, rd_valid[m], rd_data[m], i); end
            checks++; if (empty[m] !== (i == D - 1)) begin errors++; $display("FAIL drain_empty inst%0d i=%0d got %b want %b", m, i, empty[m], i == D - 1); end
         end
      end
      step(1'b0, 1'b0, '0, 1'b0);
      for (int m = 0; m < 2; m++) begin
         checks++; if ({rd_valid[m], rd_data[m]} !== {1'b0, 10'd23}) begin errors++; $display("FAIL hold_data inst%0d got v=%b d=%0d want v=0 d=23", m, rd_valid[m], rd_data[m]); end
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 30; i++) step(1'b1, 1'b0, W'(i), 1'b0);
      for (int m = 0; m < 2; m++) begin
         checks++; if ({level[m], ovf[m]} !== {5'd24, 1'b1}) begin errors++; $display("FAIL ovf_state inst%0d got level=%0d ovf=%b want level=24 ovf=1", m, level[m], ovf[m]); end
      end
      for (int i = 0; i < D; i++) begin
         step(1'b0, 1'b1, '0, 1'b0);
         for (int m = 0; m < 2; m++) begin
            int exp = (m == 1) ? i + 6 : i;
            checks++; if (rd_data[m] !== W'(exp)) begin errors++; $display("FAIL ovf_order inst%0d got %0d want %0d", m, rd_data[m], exp); end
         end
      end
   endtask

   task automatic test_full_rw();
      do_reset();
      for (int i = 0; i < D; i++) step(1'b1, 1'b0, W'(i), 1'b0);
      step(1'b1, 1'b1, 10'h3FF, 1'b0);
      for (int m = 0; m < 2; m++) begin
         checks++; if ({rd_valid[m], rd_data[m], level[m], ovf[m]} !== {1'b1, 10'd0, 5'd24, 1'b0}) begin
            errors++; $display("FAIL full_rw inst%0d got v=%b d=%0d lvl=%0d ovf=%b want v=1 d=0 lvl=24 ovf=0", m, rd_valid[m], rd_data[m], level[m], ovf[m]);
         end
      end
      for (int i = 0; i < D; i++) begin
         step(1'b0, 1'b1, '0, 1'b0);
         for (int m = 0; m < 2; m++) begin
            int exp = (i < D - 1) ? i + 1 : 'h3FF;
            checks++; if (rd_data[m] !== W'(exp)) begin errors++; $display("FAIL full_rw_order inst%0d got %0h want %0h", m, rd_data[m], exp); end
         end
      end
   endtask

   task automatic test_empty_rw();
      do_reset();
      step(1'b1, 1'b1, 10'd5, 1'b0);
      for (int m = 0; m < 2; m++) begin
         checks++; if ({rd_valid[m], udf[m], level[m]} !== {1'b0, 1'b1, 5'd1}) begin
            errors++; $display("FAIL empty_rw inst%0d got v=%b udf=%b lvl=%0d want v=0 udf=1 lvl=1", m, rd_valid[m], udf[m], level[m]);
         end
      end
      step(1'b0, 1'b1, '0, 1'b0);
      for (int m = 0; m < 2; m++) begin
         checks++; if ({rd_valid[m], rd_data[m]} !== {1'b1, 10'd5}) begin errors++; $display("FAIL empty_rw_read inst%0d got v=%b d=%0d want v=1 d=5", m, rd_valid[m], rd_data[m]); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      step(1'b0, 1'b1, '0, 1'b0);
      for (int i = 0; i < 11; i++) step(1'b1, 1'b0, W'(i + 100), 1'b0);
      step(1'b0, 1'b1, '0, 1'b0);
      #2 reset = 1'b0;
      model_reset();
      #1;
      for (int m = 0; m < 2; m++) begin
         checks++; if ({level[m], empty[m], rd_valid[m], udf[m], ovf[m]} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL mid_reset inst%0d got lvl=%0d e=%b v=%b udf=%b ovf=%b want 0 1 0 0 0", m, level[m], empty[m], rd_valid[m], udf[m], ovf[m]);
         end
      end
      @(posedge clk);
      #1 reset = 1'b1;
      step(1'b0, 1'b0, '0, 1'b1);
      for (int i = 0; i < D; i++) step(1'b1, 1'b0, W'(i), 1'b0);
      step(1'b1, 1'b0, 10'd99, 1'b1);
      for (int m = 0; m < 2; m++) begin
         checks++; if (ovf[m] !== 1'b1) begin errors++; $display("FAIL clr_vs_set inst%0d got %b want 1", m, ovf[m]); end
      end
      step(1'b0, 1'b0, '0, 1'b1);
      for (int m = 0; m < 2; m++) begin
         checks++; if (ovf[m] !== 1'b0) begin errors++; $display("FAIL err_clr inst%0d got %b want 0", m, ovf[m]); end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int ph = 0; ph < 8; ph++) begin
         int p_wr = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 20 : 50);
         if (ph == 5) do_reset();
         for (int k = 0; k < 250; k++) begin
            step($urandom_range(99) < p_wr, $urandom_range(99) < 100 - p_wr, W'($urandom), $urandom_range(15) == 0);
            for (int m = 0; m < 2; m++) begin
               int n = mq[m].size();
               checks++; if (level[m] !== LW'(n)) begin errors++; $display("FAIL rnd_level inst%0d got %0d want %0d", m, level[m], n); end
               checks++; if ({full[m], empty[m], afull[m], aempty[m]} !== {n == D, n == 0, n >= D - 4, n <= 4}) begin
                  errors++; $display("FAIL rnd_flags inst%0d got %b want %b", m, {full[m], empty[m], afull[m], aempty[m]}, {n == D, n == 0, n >= D - 4, n <= 4});
               end
               checks++; if ({rd_valid[m], rd_data[m]} !== {m_valid[m], m_data[m]}) begin
                  errors++; $display("FAIL rnd_read inst%0d got v=%b d=%0h want v=%b d=%0h", m, rd_valid[m], rd_data[m], m_valid[m], m_data[m]);
               end
               checks++; if ({ovf[m], udf[m]} !== {m_ovf[m], m_udf[m]}) begin
                  errors++; $display("FAIL rnd_errs inst%0d got %b want %b", m, {ovf[m], udf[m]}, {m_ovf[m], m_udf[m]});
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow();
      test_full_rw();
      test_empty_rw();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
